// File: rtl/vrf_bank_access_if.sv
// Request/grant and read-return bundle between the lane's requesters and the banked VRF.
// Signal names keep the direction suffixes as seen from the VRF side.
interface vrf_bank_access_if #(
    parameter int unsigned NrRdPort  = 3,
    parameter int unsigned NrWrPort  = 2,
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned DataWidth = 64
);
    logic [NrRdPort-1:0]                rd_req_i;
    logic [NrRdPort*AddrWidth-1:0]      rd_addr_i;
    logic [NrRdPort-1:0]                rd_gnt_o;
    logic [NrRdPort-1:0]                rd_valid_o;
    logic [NrRdPort*DataWidth-1:0]      rd_data_o;
    logic [NrRdPort-1:0]                rd_ready_i;
    logic [NrWrPort-1:0]                wr_req_i;
    logic [NrWrPort*AddrWidth-1:0]      wr_addr_i;
    logic [NrWrPort*DataWidth-1:0]      wr_data_i;
    logic [NrWrPort*(DataWidth/8)-1:0]  wr_strb_i;
    logic [NrWrPort-1:0]                wr_gnt_o;

    modport slave (
        input  rd_req_i, rd_addr_i, rd_ready_i, wr_req_i, wr_addr_i, wr_data_i, wr_strb_i,
        output rd_gnt_o, rd_valid_o, rd_data_o, wr_gnt_o
    );

    modport master (
        output rd_req_i, rd_addr_i, rd_ready_i, wr_req_i, wr_addr_i, wr_data_i, wr_strb_i,
        input  rd_gnt_o, rd_valid_o, rd_data_o, wr_gnt_o
    );
endinterface

// File: rtl/vrf_bank_access.sv
// Banked per-lane VRF: per-bank round-robin arbitration of read/write requesters,
// 1-cycle read latency and a depth-1 fall-through buffer on each read port.
module vrf_bank_access #(
    parameter int unsigned NrRdPort  = 3,
    parameter int unsigned NrWrPort  = 2,
    parameter int unsigned NrBank    = 8,
    parameter int unsigned BankDepth = 16,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = $clog2(NrBank * BankDepth)
) (
    input logic              clk_i,
    input logic              rst_i,
    vrf_bank_access_if.slave vrf_if
);
    localparam int unsigned NrReq    = NrRdPort + NrWrPort;
    localparam int unsigned BankBits = $clog2(NrBank);
    localparam int unsigned RowWidth = AddrWidth - BankBits;
    localparam int unsigned ReqW     = $clog2(NrReq);
    localparam int unsigned StrbW    = DataWidth / 8;

    logic [NrReq-1:0]     eff_req, gnt;
    logic [AddrWidth-1:0] req_addr [NrReq];
    logic [BankBits-1:0]  req_bank [NrReq];
    logic [RowWidth-1:0]  req_row  [NrReq];

    logic [NrReq-1:0]     bank_gnt   [NrBank];
    logic [ReqW-1:0]      ptr_q      [NrBank];
    logic [ReqW-1:0]      ptr_d      [NrBank];
    logic [NrBank-1:0]    bank_we, bank_re;
    logic [RowWidth-1:0]  bank_row   [NrBank];
    logic [DataWidth-1:0] bank_wdata [NrBank];
    logic [StrbW-1:0]     bank_wstrb [NrBank];
    logic [DataWidth-1:0] bank_rdata_q [NrBank];
    logic [DataWidth-1:0] mem_q [NrBank][BankDepth];

    logic [NrRdPort-1:0]  valid_q, buf_full_q, buf_full_d;
    logic [BankBits-1:0]  bsel_q     [NrRdPort];
    logic [DataWidth-1:0] buf_data_q [NrRdPort];
    logic [DataWidth-1:0] port_rdata [NrRdPort];

    // Reads are only presented when the data can be accepted, so nothing is ever dropped.
    always_comb begin
        eff_req  = '0;
        req_addr = '{default: '0};
        for (int p = 0; p < NrRdPort; p++) begin
            req_addr[p] = vrf_if.rd_addr_i[p*AddrWidth +: AddrWidth];
            eff_req[p]  = vrf_if.rd_req_i[p] & vrf_if.rd_ready_i[p] & ~buf_full_q[p];
        end
        for (int w = 0; w < NrWrPort; w++) begin
            req_addr[NrRdPort+w] = vrf_if.wr_addr_i[w*AddrWidth +: AddrWidth];
            eff_req[NrRdPort+w]  = vrf_if.wr_req_i[w];
        end
        for (int r = 0; r < NrReq; r++) begin
            req_bank[r] = req_addr[r][BankBits-1:0];
            req_row[r]  = req_addr[r][AddrWidth-1:BankBits];
        end
    end

    always_comb begin
        logic [ReqW:0]   cand;
        logic [ReqW-1:0] cidx;
        logic            found;
        cand  = '0;
        cidx  = '0;
        found = 1'b0;
        gnt   = '0;
        for (int b = 0; b < NrBank; b++) begin
            bank_gnt[b] = '0;
            ptr_d[b]    = ptr_q[b];
            found       = 1'b0;
            // Scan requesters starting at the pointer, wrapping modulo NrReq.
            for (int k = 0; k < NrReq; k++) begin
                cand = {1'b0, ptr_q[b]} + (ReqW+1)'(k);
                if (cand >= (ReqW+1)'(NrReq)) begin
                    cand = cand - (ReqW+1)'(NrReq);
                end
                cidx = cand[ReqW-1:0];
                if (!found && eff_req[cidx] && (req_bank[cidx] == BankBits'(b))) begin
                    found             = 1'b1;
                    bank_gnt[b][cidx] = 1'b1;
                    ptr_d[b]          = (cand == (ReqW+1)'(NrReq - 1)) ? '0 : ReqW'(cand + 1'b1);
                end
            end
            gnt = gnt | bank_gnt[b];
        end
    end

    assign vrf_if.rd_gnt_o = gnt[NrRdPort-1:0];
    assign vrf_if.wr_gnt_o = gnt[NrReq-1:NrRdPort];

    always_comb begin
        bank_re = '0;
        bank_we = '0;
        for (int b = 0; b < NrBank; b++) begin
            bank_re[b]    = |bank_gnt[b][NrRdPort-1:0];
            bank_row[b]   = '0;
            bank_wdata[b] = '0;
            bank_wstrb[b] = '0;
            for (int r = 0; r < NrReq; r++) begin
                if (bank_gnt[b][r]) begin
                    bank_row[b] = req_row[r];
                end
            end
            for (int w = 0; w < NrWrPort; w++) begin
                if (bank_gnt[b][NrRdPort+w]) begin
                    bank_we[b]    = 1'b1;
                    bank_wdata[b] = vrf_if.wr_data_i[w*DataWidth +: DataWidth];
                    bank_wstrb[b] = vrf_if.wr_strb_i[w*StrbW +: StrbW];
                end
            end
        end
    end

    always_comb begin
        buf_full_d        = '0;
        vrf_if.rd_valid_o = '0;
        vrf_if.rd_data_o  = '0;
        for (int p = 0; p < NrRdPort; p++) begin
            port_rdata[p] = bank_rdata_q[bsel_q[p]];
            buf_full_d[p] = buf_full_q[p] ? ~vrf_if.rd_ready_i[p]
                                          : (valid_q[p] & ~vrf_if.rd_ready_i[p]);
            vrf_if.rd_valid_o[p] = valid_q[p] | buf_full_q[p];
            vrf_if.rd_data_o[p*DataWidth +: DataWidth] = buf_full_q[p] ? buf_data_q[p]
                                                                        : port_rdata[p];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            buf_full_q <= '0;
            for (int b = 0; b < NrBank; b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            valid_q    <= gnt[NrRdPort-1:0];
            buf_full_q <= buf_full_d;
            for (int b = 0; b < NrBank; b++) begin
                ptr_q[b] <= ptr_d[b];
            end
        end
    end

    // Storage and data-path registers carry no reset; their contents are qualified elsewhere.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NrBank; b++) begin
            if (bank_re[b]) begin
                bank_rdata_q[b] <= mem_q[b][bank_row[b]];
            end
            if (bank_we[b]) begin
                for (int i = 0; i < StrbW; i++) begin
                    if (bank_wstrb[b][i]) begin
                        mem_q[b][bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
                    end
                end
            end
        end
        for (int p = 0; p < NrRdPort; p++) begin
            if (gnt[p]) begin
                bsel_q[p] <= req_bank[p];
            end
            if (buf_full_d[p] && !buf_full_q[p]) begin
                buf_data_q[p] <= port_rdata[p];
            end
        end
    end
endmodule

// File: tb/tb_vrf_bank_access.sv
// Randomized and directed checks of vrf_bank_access against a word-addressed
// memory model with per-port return queues and per-bank round-robin pointers.
module tb_vrf_bank_access;
    localparam int NrRd   = 3;
    localparam int NrWr   = 2;
    localparam int NrBank = 8;
    localparam int Depth  = 16;
    localparam int DW     = 64;
    localparam int AW     = 7;
    localparam int SW     = 8;
    localparam int NrReq  = NrRd + NrWr;

    logic clk, rst;

    vrf_bank_access_if #(
        .NrRdPort (NrRd),
        .NrWrPort (NrWr),
        .AddrWidth(AW),
        .DataWidth(DW)
    ) bus ();

    vrf_bank_access #(
        .NrRdPort (NrRd),
        .NrWrPort (NrWr),
        .NrBank   (NrBank),
        .BankDepth(Depth),
        .DataWidth(DW),
        .AddrWidth(AW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .vrf_if(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          t_rd_req   [NrRd];
    logic [AW-1:0] t_rd_addr  [NrRd];
    logic          t_rd_ready [NrRd];
    logic          t_wr_req   [NrWr];
    logic [AW-1:0] t_wr_addr  [NrWr];
    logic [DW-1:0] t_wr_data  [NrWr];
    logic [SW-1:0] t_wr_strb  [NrWr];

    logic [DW-1:0]    m_mem [NrBank*Depth];
    logic [DW-1:0]    m_qd  [NrRd][$];
    int               m_qa  [NrRd][$];
    int               m_ptr [NrBank];
    int               m_win [NrBank];
    logic [NrReq-1:0] m_gnt;
    logic [NrRd-1:0]  m_vld;
    int               cyc, n_vec, n_err;

    function automatic logic [DW-1:0] pre(input int a);
        return {32'hC0DE_0000 | 32'(a), 32'h5A5A_0000 + 32'(a * 3)};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        for (int p = 0; p < NrRd; p++) begin
            t_rd_req[p]   = 1'b0;
            t_rd_addr[p]  = '0;
            t_rd_ready[p] = 1'b1;
        end
        for (int w = 0; w < NrWr; w++) begin
            t_wr_req[w]  = 1'b0;
            t_wr_addr[w] = '0;
            t_wr_data[w] = '0;
            t_wr_strb[w] = '0;
        end
    endtask

    task automatic apply();
        for (int p = 0; p < NrRd; p++) begin
            bus.rd_req_i[p]             = t_rd_req[p];
            bus.rd_addr_i[p*AW +: AW]   = t_rd_addr[p];
            bus.rd_ready_i[p]           = t_rd_ready[p];
        end
        for (int w = 0; w < NrWr; w++) begin
            bus.wr_req_i[w]             = t_wr_req[w];
            bus.wr_addr_i[w*AW +: AW]   = t_wr_addr[w];
            bus.wr_data_i[w*DW +: DW]   = t_wr_data[w];
            bus.wr_strb_i[w*SW +: SW]   = t_wr_strb[w];
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NrRd; p++) begin
            m_qd[p].delete();
            m_qa[p].delete();
        end
        for (int b = 0; b < NrBank; b++) begin
            m_ptr[b] = 0;
        end
    endtask

    // Drive at the falling edge, predict grants/outputs and compare.
    task automatic settle();
        logic [NrReq-1:0] eff;
        int               addr_r [NrReq];
        @(negedge clk);
        apply();
        #1;
        eff = '0;
        for (int p = 0; p < NrRd; p++) begin
            m_vld[p]  = (m_qd[p].size() != 0);
            eff[p]    = t_rd_req[p] && t_rd_ready[p] && !(m_vld[p] && (m_qa[p][0] < cyc));
            addr_r[p] = int'(t_rd_addr[p]);
        end
        for (int w = 0; w < NrWr; w++) begin
            eff[NrRd+w]    = t_wr_req[w];
            addr_r[NrRd+w] = int'(t_wr_addr[w]);
        end
        m_gnt = '0;
        for (int b = 0; b < NrBank; b++) begin
            m_win[b] = -1;
            for (int k = 0; k < NrReq; k++) begin
                int r;
                r = (m_ptr[b] + k) % NrReq;
                if (m_win[b] < 0 && eff[r] && (addr_r[r] % NrBank) == b) begin
                    m_win[b] = r;
                    m_gnt[r] = 1'b1;
                end
            end
        end
        check("rd_gnt", DW'(bus.rd_gnt_o), DW'(m_gnt[NrRd-1:0]));
        check("wr_gnt", DW'(bus.wr_gnt_o), DW'(m_gnt[NrReq-1:NrRd]));
        check("rd_valid", DW'(bus.rd_valid_o), DW'(m_vld));
        for (int p = 0; p < NrRd; p++) begin
            if (m_vld[p]) begin
                check($sformatf("rd_data%0d", p), bus.rd_data_o[p*DW +: DW], m_qd[p][0]);
            end
        end
    endtask

    // Advance the model across the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < NrRd; p++) begin
            if (m_vld[p] && t_rd_ready[p]) begin
                void'(m_qd[p].pop_front());
                void'(m_qa[p].pop_front());
            end
        end
        for (int b = 0; b < NrBank; b++) begin
            if (m_win[b] >= 0 && m_win[b] < NrRd) begin
                m_qd[m_win[b]].push_back(m_mem[t_rd_addr[m_win[b]]]);
                m_qa[m_win[b]].push_back(cyc + 1);
            end
        end
        for (int b = 0; b < NrBank; b++) begin
            if (m_win[b] >= NrRd) begin
                int w;
                w = m_win[b] - NrRd;
                for (int i = 0; i < SW; i++) begin
                    if (t_wr_strb[w][i]) begin
                        m_mem[t_wr_addr[w]][i*8 +: 8] = t_wr_data[w][i*8 +: 8];
                    end
                end
            end
            if (m_win[b] >= 0) begin
                m_ptr[b] = (m_win[b] + 1) % NrReq;
            end
        end
        cyc++;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [2:0] conf_exp [4];
        conf_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        for (int a = 0; a < NrBank * Depth; a++) begin
            m_mem[a] = 'x;
        end
        model_reset();
        idle();
        apply();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        settle();
        check("reset_valid", DW'(bus.rd_valid_o), DW'(3'b000));
        tick();

        // Preload every word so reads never return undefined data.
        for (int a = 0; a < NrBank * Depth; a++) begin
            idle();
            t_wr_req[0]  = 1'b1;
            t_wr_addr[0] = AW'(a);
            t_wr_data[0] = pre(a);
            t_wr_strb[0] = 8'hFF;
            step();
        end

        // Full write followed by read.
        idle();
        t_wr_req[0]  = 1'b1;
        t_wr_addr[0] = 7'h09;
        t_wr_data[0] = 64'h1122_3344_5566_7788;
        t_wr_strb[0] = 8'hFF;
        settle();
        check("t1_wr_gnt", DW'(bus.wr_gnt_o), DW'(2'b01));
        tick();
        idle();
        t_rd_req[0]  = 1'b1;
        t_rd_addr[0] = 7'h09;
        settle();
        check("t1_rd_gnt", DW'(bus.rd_gnt_o), DW'(3'b001));
        tick();
        idle();
        settle();
        check("t1_valid", DW'(bus.rd_valid_o[0]), DW'(1'b1));
        check("t1_data", bus.rd_data_o[DW-1:0], 64'h1122_3344_5566_7788);
        tick();

        // Partial strobe.
        idle();
        t_wr_req[0]  = 1'b1;
        t_wr_addr[0] = 7'h12;
        t_wr_data[0] = '0;
        t_wr_strb[0] = 8'hFF;
        step();
        t_wr_data[0] = '1;
        t_wr_strb[0] = 8'h0F;
        step();
        idle();
        t_rd_req[0]  = 1'b1;
        t_rd_addr[0] = 7'h12;
        step();
        idle();
        settle();
        check("t2_data", bus.rd_data_o[DW-1:0], 64'h0000_0000_FFFF_FFFF);
        tick();

        // Back-pressure: data held while ready is low.
        idle();
        t_rd_req[0]  = 1'b1;
        t_rd_addr[0] = 7'h09;
        step();
        t_rd_ready[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("bp_valid", DW'(bus.rd_valid_o[0]), DW'(1'b1));
            check("bp_gnt", DW'(bus.rd_gnt_o[0]), DW'(1'b0));
            check("bp_data", bus.rd_data_o[DW-1:0], 64'h1122_3344_5566_7788);
            tick();
        end
        idle();
        settle();
        check("bp_drain", bus.rd_data_o[DW-1:0], 64'h1122_3344_5566_7788);
        tick();
        settle();
        check("bp_empty", DW'(bus.rd_valid_o[0]), DW'(1'b0));
        tick();

        // Asynchronous reset while read data is on the output.
        idle();
        t_rd_req[0]  = 1'b1;
        t_rd_addr[0] = 7'h09;
        step();
        idle();
        t_rd_ready[0] = 1'b0;
        settle();
        check("pre_rst_valid", DW'(bus.rd_valid_o[0]), DW'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_valid", DW'(bus.rd_valid_o), DW'(3'b000));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three readers on bank 3 rotate from index 0; port 1 then moves to bank 4.
        idle();
        t_rd_req[0]  = 1'b1;
        t_rd_addr[0] = 7'h03;
        t_rd_req[1]  = 1'b1;
        t_rd_addr[1] = 7'h0B;
        t_rd_req[2]  = 1'b1;
        t_rd_addr[2] = 7'h13;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("conf_gnt", DW'(bus.rd_gnt_o), DW'(conf_exp[i]));
            tick();
        end
        t_rd_addr[1] = 7'h04;
        settle();
        check("conf_b4_a", DW'(bus.rd_gnt_o), DW'(3'b110));
        tick();
        settle();
        check("conf_b4_b", DW'(bus.rd_gnt_o), DW'(3'b011));
        tick();

        // Read and write collide on bank 5: read first, returning the old word.
        idle();
        t_rd_req[0]  = 1'b1;
        t_rd_addr[0] = 7'h0D;
        t_wr_req[0]  = 1'b1;
        t_wr_addr[0] = 7'h0D;
        t_wr_data[0] = 64'hDEAD_BEEF_CAFE_F00D;
        t_wr_strb[0] = 8'hFF;
        settle();
        check("mix_rd_gnt", DW'(bus.rd_gnt_o), DW'(3'b001));
        check("mix_wr_gnt", DW'(bus.wr_gnt_o), DW'(2'b00));
        tick();
        settle();
        check("mix_wr_gnt2", DW'(bus.wr_gnt_o), DW'(2'b01));
        check("mix_rd_gnt2", DW'(bus.rd_gnt_o), DW'(3'b000));
        check("mix_old", bus.rd_data_o[DW-1:0], pre(13));
        tick();
        idle();
        t_rd_req[0]  = 1'b1;
        t_rd_addr[0] = 7'h0D;
        step();
        idle();
        settle();
        check("mix_new", bus.rd_data_o[DW-1:0], 64'hDEAD_BEEF_CAFE_F00D);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic narrow;
            narrow = 1'($urandom_range(0, 1));
            for (int p = 0; p < NrRd; p++) begin
                t_rd_req[p]   = 1'($urandom_range(0, 1));
                t_rd_addr[p]  = narrow ? AW'($urandom_range(0, 23)) : AW'($urandom_range(0, 127));
                t_rd_ready[p] = ($urandom_range(0, 3) != 0);
            end
            for (int w = 0; w < NrWr; w++) begin
                t_wr_req[w]  = 1'($urandom_range(0, 1));
                t_wr_addr[w] = narrow ? AW'($urandom_range(0, 23)) : AW'($urandom_range(0, 127));
                t_wr_data[w] = {$urandom(), $urandom()};
                t_wr_strb[w] = SW'($urandom());
            end
            step();
        end

        idle();
        for (int i = 0; i < 3; i++) begin
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vrf_bank_access.md
Name: vrf_bank_access

Overview:
- Per-lane banked vector-register-file (VRF) access block.
- It receives read requests from operand queues and write requests from vector functional units (VFU result ports).
- Each request is steered to a bank chosen by the low address bits.
- Conflicts inside a bank are resolved by one round-robin arbiter per bank.
- Read data returns through a per-read-port fall-through output buffer with a valid/ready handshake.

Parameters:
- NrRdPort, 3, number of read requesters (operand queues).
- NrWrPort, 2, number of write requesters (VFU result ports).
- NrBank, 8, number of single-port banks; power of 2.
- BankDepth, 16, words per bank.
- DataWidth, 64, bits per VRF word.
- AddrWidth, $clog2(NrBank*BankDepth) (=7), lane-local word address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- rd_req_i  in  NrRdPort  read request per port.
- rd_addr_i  in  NrRdPort*AddrWidth  read word address per port.
- rd_gnt_o  out  NrRdPort  read accepted this cycle (combinational).
- rd_valid_o  out  NrRdPort  read data valid.
- rd_data_o  out  NrRdPort*DataWidth  read data.
- rd_ready_i  in  NrRdPort  consumer ready for read data.
- wr_req_i  in  NrWrPort  write request.
- wr_addr_i  in  NrWrPort*AddrWidth  write word address.
- wr_data_i  in  NrWrPort*DataWidth  write data.
- wr_strb_i  in  NrWrPort*(DataWidth/8)  byte write enables.
- wr_gnt_o  out  NrWrPort  write accepted this cycle (combinational).

Behaviour:
- Address split: bank = addr[$clog2(NrBank)-1:0]; row = addr >> $clog2(NrBank).
- Requester index order: read ports 0..NrRdPort-1, then write ports NrRdPort..NrRdPort+NrWrPort-1.
- Effective read request = rd_req_i[p] & rd_ready_i[p] & ~buf_full[p]. Because of this gating, read data is never dropped.
- Effective write request = wr_req_i[w].
- Per-bank arbitration:
  - One arbiter per bank sees only the requesters that target that bank.
  - It grants at most one requester per cycle, combinationally, in the same cycle as the request.
  - A requester not granted simply holds its request and retries.
- Round-robin rule:
  - After reset the priority pointer is 0, so the lowest index wins.
  - After each grant, the pointer moves to (winner+1) mod NrReq.
  - Each bank keeps its own pointer.
  - The pointer does not change in a cycle with no request.
- gnt outputs are the OR of all bank grants for that requester; at most one bank per requester.
- Write path: a granted write updates only the bytes whose strobe is 1, at the clock edge of the grant cycle.
- Read path:
  - A granted read samples the bank row at the grant edge.
  - Data arrives the cycle after the grant (1-cycle latency).
  - Bank select and valid are registered per port: valid_q[p] <= rd_gnt_o[p], bsel_q[p] <= bank.
- A write in cycle t is visible to a read granted in cycle t+1 or later. A read and a write to the same bank in the same cycle are serialized by the arbiter.
- Fall-through output buffer, per read port, depth 1:
  - Empty and valid_q: rd_valid_o=1 and rd_data_o = bank data, combinationally.
  - If rd_ready_i=1 the data is consumed; otherwise it is captured and buf_full=1.
  - Full: rd_valid_o=1 with the stored data; it clears when rd_ready_i=1.
  - Data is never overwritten while full.
- Ordering: a port's read data returns in grant order.
- Reset:
  - Clears valid_q, buf_full and all arbiter pointers; rd_valid_o=0.
  - Bank contents are not reset (X until written).
  - rd_gnt_o/wr_gnt_o depend only on current requests after reset.
- Reset mid-operation discards in-flight and buffered read data. Any write granted in the reset cycle may or may not take effect; it is not relied upon.
- No back-pressure is applied on writes other than arbitration loss.

Test Plan:
- Write port 0: addr 0x09, data 0x1122334455667788, strb 0xFF, then read port 0 addr 0x09 with ready=1 -> wr_gnt same cycle; rd_gnt next request cycle; rd_valid_o=1 one cycle later with 0x1122334455667788.
- Partial strobe: write 0x0 then 0xFFFF_FFFF_FFFF_FFFF strb 0x0F to addr 0x12 -> read returns 0x00000000FFFFFFFF.
- Conflict: read ports 0,1,2 all request bank 3 (addrs 0x03, 0x0B, 0x13) continuously -> grants port 0, 1, 2, 0, ... one per cycle. Meanwhile read port 1 at bank 4 alone is granted immediately.
- Mixed conflict: read port 0 and write port 0 both target bank 5 -> after reset read wins first, write granted next cycle; the read returns the old data.
- Back-pressure: read granted with ready=1, then ready=0 in the data cycle -> data held, rd_valid_o=1, rd_gnt_o=0 for that port until ready=1. Data is unchanged when drained.
- Async reset asserted while rd_valid_o=1 -> rd_valid_o drops to 0 immediately; after release, arbitration restarts at index 0.
